// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Purpose:
//   Scans a 4x4 active-low matrix keypad one column at a time, synchronizes
//   the row returns, debounces both press and release, and reports each
//   accepted key exactly once as a 4-bit code {row_idx, col_idx}.
//
// Parameters:
//   SCAN_DIV     - clock cycles each column stays driven (>= 4)
//   DEBOUNCE_CNT - consecutive matching samples to accept a press or a
//                  release (1..255)
//
// Ports:
//   clk        - system clock
//   rst        - asynchronous, active-high reset
//   row_in     - keypad rows, active-low, asynchronous to clk
//   col_out    - column drive, one-hot active-low
//   keypad_out - code of the last accepted key (4*row + col)
//   key_valid  - one-cycle strobe when a new key is accepted
//   key_held   - high while the accepted key is still pressed
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] keypad_out,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t        r_state;
    logic [3:0]    r_sync1;
    logic [3:0]    r_rows_s;     // synchronized rows; every decision uses this
    logic [DW-1:0] r_dwell;
    logic [CW-1:0] r_cnt;        // shared press/release debounce counter
    logic [1:0]    r_col_idx;
    logic [1:0]    r_row_idx;
    logic [3:0]    r_pattern;    // rows_s snapshot taken at detection

    logic [1:0]    w_row_idx;
    logic          w_any_low;
    logic [1:0]    w_col_next;
    logic [3:0]    w_col_next_drive;

    assign w_any_low        = (r_rows_s != 4'b1111);
    assign w_col_next       = r_col_idx + 2'd1;
    assign w_col_next_drive = ~(4'b0001 << w_col_next);

    // Priority encoder: scanning downward lets the lowest low row win.
    always_comb begin
        // NOTE: default assignment first so this block can never infer a latch.
        w_row_idx = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!r_rows_s[r]) begin
                w_row_idx = 2'(r);
            end
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register in this block sees the values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 4'b1111;
            r_rows_s   <= 4'b1111;
            r_state    <= SCAN;
            r_dwell    <= '0;
            r_cnt      <= '0;
            r_col_idx  <= 2'd0;
            r_row_idx  <= 2'd0;
            r_pattern  <= 4'b1111;
            col_out    <= 4'b1110;
            keypad_out <= 4'b0000;
            key_valid  <= 1'b0;
            key_held   <= 1'b0;
        end else begin
            // Two-flop synchronizer for the asynchronous row returns.
            r_sync1  <= row_in;
            r_rows_s <= r_sync1;

            key_valid <= 1'b0;

            case (r_state)
                SCAN: begin
                    if (r_dwell == DWELL_LAST) begin
                        r_dwell <= '0;
                        if (w_any_low) begin
                            // Freeze the column and remember what we saw.
                            r_row_idx <= w_row_idx;
                            r_pattern <= r_rows_s;
                            r_cnt     <= '0;
                            r_state   <= DEBOUNCE;
                        end else begin
                            r_col_idx <= w_col_next;
                            col_out   <= w_col_next_drive;
                        end
                    end else begin
                        r_dwell <= r_dwell + DW'(1);
                    end
                end

                DEBOUNCE: begin
                    if (r_rows_s != r_pattern) begin
                        // Bounce or noise: drop silently and keep scanning.
                        r_cnt     <= '0;
                        r_dwell   <= '0;
                        r_col_idx <= w_col_next;
                        col_out   <= w_col_next_drive;
                        r_state   <= SCAN;
                    end else if (r_cnt == CNT_LAST) begin
                        // This match is sample number DEBOUNCE_CNT.
                        r_cnt      <= '0;
                        key_valid  <= 1'b1;
                        keypad_out <= {r_row_idx, r_col_idx};
                        key_held   <= 1'b1;
                        r_state    <= HELD;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                HELD: begin
                    // Column stays frozen; any low row restarts the release
                    // qualification, which also masks a second key here.
                    if (w_any_low) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        key_held  <= 1'b0;
                        r_dwell   <= '0;
                        r_col_idx <= w_col_next;
                        col_out   <= w_col_next_drive;
                        r_state   <= SCAN;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                default: begin
                    r_state <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//
// Self-checking bench for keypad_scanner. A keypad emulator turns a 16-bit
// "pressed" set plus the DUT column drive into row_in. A timeline model
// (timestamps of the current scan origin, detection and last low row)
// predicts every output each cycle; directed literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  keypad_out;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = '0;

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row_in     (row_in),
        .col_out    (col_out),
        .keypad_out (keypad_out),
        .key_valid  (key_valid),
        .key_held   (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a row reads low when a pressed key in it sits on the
    // currently driven (low) column.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[4*r+c] && !col_out[c]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- timeline reference model ----------------
    typedef enum {P_SCAN, P_CONFIRM, P_HOLD} phase_t;

    phase_t     m_phase = P_SCAN;
    int         m_cyc   = 0;
    int         m_t0    = 0;   // cycle whose dwell position is 0
    int         m_tdet  = 0;   // cycle of the detecting sample
    int         m_tlow  = 0;   // last cycle any row was low while holding
    int         m_row   = 0;
    int         m_kcol  = 0;
    logic [3:0] m_pat   = 4'hF;
    logic [3:0] m_s1    = 4'hF;
    logic [3:0] m_rs    = 4'hF;
    int         e_col   = 0;
    logic [3:0] e_code  = 4'h0;
    logic       e_valid = 1'b0;
    logic       e_held  = 1'b0;

    int         n_pulses  = 0;
    logic       prev_held = 1'b0;
    logic [3:0] fall_col  = 4'h0;

    function automatic logic [3:0] col_drive(input int c);
        logic [3:0] d;
        d = 4'hF;
        d[c[1:0]] = 1'b0;
        return d;
    endfunction

    function automatic int lowest_row(input logic [3:0] rs);
        for (int r = 0; r < 4; r++) begin
            if (!rs[r]) return r;
        end
        return 0;
    endfunction

    // Advance the model from the current cycle to the next one.
    task automatic model_step();
        e_valid = 1'b0;
        case (m_phase)
            P_SCAN: begin
                if ((m_cyc - m_t0) % SCAN_DIV == SCAN_DIV - 1) begin
                    if (m_rs != 4'hF) begin
                        m_phase = P_CONFIRM;
                        m_tdet  = m_cyc;
                        m_pat   = m_rs;
                        m_kcol  = e_col;
                        m_row   = lowest_row(m_rs);
                    end else begin
                        e_col = (e_col + 1) % 4;
                    end
                end
            end
            P_CONFIRM: begin
                if (m_rs != m_pat) begin
                    m_phase = P_SCAN;
                    e_col   = (m_kcol + 1) % 4;
                    m_t0    = m_cyc + 1;
                end else if (m_cyc - m_tdet == DEBOUNCE_CNT) begin
                    e_valid = 1'b1;
                    e_code  = 4'(4 * m_row + m_kcol);
                    e_held  = 1'b1;
                    m_phase = P_HOLD;
                    m_tlow  = m_cyc;
                end
            end
            P_HOLD: begin
                if (m_rs != 4'hF) begin
                    m_tlow = m_cyc;
                end else if (m_cyc - m_tlow == DEBOUNCE_CNT) begin
                    e_held  = 1'b0;
                    m_phase = P_SCAN;
                    e_col   = (m_kcol + 1) % 4;
                    m_t0    = m_cyc + 1;
                end
            end
            default: m_phase = P_SCAN;
        endcase
        m_rs = m_s1;
        m_s1 = row_in;
    endtask

    // One compare per cycle, mid-cycle, then advance the model.
    always @(negedge clk) begin
        if (rst) begin
            check("reset_outputs", 32'({col_out, keypad_out, key_valid, key_held}),
                  32'({4'b1110, 4'b0000, 1'b0, 1'b0}));
            m_phase   = P_SCAN;
            m_t0      = m_cyc;
            e_col     = 0;
            e_code    = 4'h0;
            e_valid   = 1'b0;
            e_held    = 1'b0;
            m_rs      = 4'hF;
            m_s1      = row_in;
            prev_held = 1'b0;
        end else begin
            check("cycle_outputs", 32'({col_out, keypad_out, key_valid, key_held}),
                  32'({col_drive(e_col), e_code, e_valid, e_held}));
            if (key_valid) n_pulses++;
            if (prev_held && !key_held) fall_col = col_out;
            prev_held = key_held;
            model_step();
        end
        m_cyc++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic press_set(input logic [15:0] mask);
        @(posedge clk);
        #2 pressed = mask;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input phase_t p, input int max_cyc, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            #1;
            if (m_phase == p) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic pulse_reset(input string name);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check(name, 32'({col_out, keypad_out, key_valid, key_held}),
              32'({4'b1110, 4'b0000, 1'b0, 1'b0}));
        pressed = '0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check({name, "_col_restart"}, 32'(col_out), 32'(4'b1110));
    endtask

    logic [3:0] idle_seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    initial begin
        int         p0;
        int         p1;
        logic [15:0] m;
        int         hold;
        int         bounce;

        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // Idle scanning: one column step every SCAN_DIV cycles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("idle_col", 32'(col_out), 32'(idle_seq[i]));
            if (i < 4) repeat (SCAN_DIV - 1) @(negedge clk);
        end
        check("idle_pulses", 32'(n_pulses), 32'd0);
        check("idle_code", 32'(keypad_out), 32'h0);

        // Clean press row 0 / column 3.
        p0 = n_pulses;
        fall_col = 4'h0;
        press_set(16'h0008);
        wait_cycles(100);
        check("k3_code", 32'(keypad_out), 32'h3);
        check("k3_held", 32'(key_held), 32'd1);
        press_set(16'h0000);
        wait_cycles(40);
        check("k3_pulses", 32'(n_pulses - p0), 32'd1);
        check("k3_released", 32'(key_held), 32'd0);
        check("k3_resume_col", 32'(fall_col), 32'(4'b1110));

        // Bouncy press row 0 / column 1.
        p0 = n_pulses;
        for (int i = 0; i < 4; i++) begin
            press_set(16'h0002);
            wait_cycles(3);
            press_set(16'h0000);
            wait_cycles(3);
        end
        check("bounce_no_strobe", 32'(n_pulses - p0), 32'd0);
        press_set(16'h0002);
        wait_cycles(80);
        check("bounce_pulses", 32'(n_pulses - p0), 32'd1);
        check("bounce_code", 32'(keypad_out), 32'h1);
        press_set(16'h0000);
        wait_cycles(40);

        // Rows 1 and 2 together on column 2: lowest row wins.
        p0 = n_pulses;
        press_set(16'h0440);
        wait_cycles(80);
        check("multi_code", 32'(keypad_out), 32'h6);
        press_set(16'h0000);
        wait_cycles(40);
        check("multi_pulses", 32'(n_pulses - p0), 32'd1);

        // Second key while holding 0011 is ignored until full release.
        press_set(16'h0008);
        wait_cycles(60);
        check("hold2_first", 32'(keypad_out), 32'h3);
        p1 = n_pulses;
        press_set(16'h8008);
        wait_cycles(50);
        check("hold2_no_strobe", 32'(n_pulses - p1), 32'd0);
        check("hold2_code_kept", 32'(keypad_out), 32'h3);
        press_set(16'h0000);
        wait_cycles(40);
        check("hold2_code_after_rel", 32'(keypad_out), 32'h3);
        press_set(16'h8000);
        wait_cycles(60);
        check("hold2_repress_code", 32'(keypad_out), 32'hF);
        check("hold2_repress_pulses", 32'(n_pulses - p1), 32'd1);
        press_set(16'h0000);
        wait_cycles(40);

        // Reset during DEBOUNCE: no strobe at all.
        p0 = n_pulses;
        press_set(16'h0020);
        wait_phase(P_CONFIRM, 40, "wait_debounce");
        pulse_reset("rst_in_debounce");
        wait_cycles(40);
        check("rst_debounce_pulses", 32'(n_pulses - p0), 32'd0);

        // Reset during HELD.
        p0 = n_pulses;
        press_set(16'h0020);
        wait_phase(P_HOLD, 60, "wait_held");
        wait_cycles(3);
        check("held_before_rst", 32'({keypad_out, key_held}), 32'({4'h5, 1'b1}));
        pulse_reset("rst_in_held");
        wait_cycles(40);
        check("rst_held_pulses", 32'(n_pulses - p0), 32'd1);
        check("rst_held_code", 32'(keypad_out), 32'h0);

        // Randomized episodes checked by the per-cycle model.
        for (int ep = 0; ep < 40; ep++) begin
            m = 16'(1) << $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) m = m | (16'(1) << $urandom_range(0, 15));
            hold   = int'($urandom_range(2, 60));
            bounce = int'($urandom_range(0, 3));
            for (int b = 0; b < bounce; b++) begin
                press_set(m);
                wait_cycles(int'($urandom_range(1, 6)));
                press_set(16'h0000);
                wait_cycles(int'($urandom_range(1, 4)));
            end
            press_set(m);
            wait_cycles(hold);
            press_set(16'h0000);
            wait_cycles(int'($urandom_range(1, 40)));
        end

        wait_cycles(50);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
